cc_line_fill_engine: RTL and testbench
======================================

CC_LINE_FILL_ENGINE -- requirements
Module: cc_line_fill_engine

Interface
REQ-001 SHALL have parameter BEAT_W, default 64, memory R-channel beat width in bits.
REQ-002 SHALL have parameter BEATS, default 8, beats per cache line (power of 2, 2..16).
REQ-003 SHALL have parameter IDX_W, default 9, SRAM index width.
REQ-004 SHALL have parameter TAG_W, default 17, address tag width; SRAM tag word is TAG_W+1 bits: {valid, tag}.
REQ-005 SHALL have parameter WRAP_MODE, default 1; 1 = critical-word-first wrap fill, 0 = incrementing fill from beat 0.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset, sampled on rising clk.
REQ-007 SHALL have ports: miss_addr_fifo_empty_i in 1; miss_addr_fifo_rdata_i in 32 show-ahead miss address; miss_addr_fifo_rden_o out 1 pop.
REQ-008 SHALL have ports: mem_rdata_i in BEAT_W; mem_rresp_i in 2; mem_rlast_i in 1; mem_rvalid_i in 1; mem_rready_o out 1.
REQ-009 SHALL have ports: wren_o out 1; waddr_o out IDX_W; wdata_tag_o out TAG_W+1; wdata_data_o out BEAT_W*BEATS.
REQ-010 SHALL have ports: busy_o out 1 engine not IDLE; fill_done_o out 1 one-cycle pulse with successful write; fill_err_o out 1 one-cycle pulse on aborted fill.

Function
REQ-011 SHALL decode the miss address as offset = low log2(BEAT_W*BEATS/8) bits, index = next IDX_W bits, tag = next TAG_W bits; start beat = offset >> log2(BEAT_W/8).
REQ-012 SHALL implement states IDLE, FILL, WRITE.
REQ-013 IDLE: if !miss_addr_fifo_empty_i, SHALL assert miss_addr_fifo_rden_o combinationally for one cycle, latch tag/index/start beat, and enter FILL next cycle.
REQ-014 FILL: SHALL drive mem_rready_o=1; mem_rready_o SHALL be 0 in IDLE and WRITE.
REQ-015 Each accepted beat (mem_rvalid_i & mem_rready_o) SHALL be stored in slot (start+cnt) mod BEATS when WRAP_MODE=1, slot cnt when WRAP_MODE=0; cnt is a log2(BEATS)-bit counter, reset to 0 on entering FILL, wrapping naturally.
REQ-016 SHALL set a sticky error flag if any accepted beat has mem_rresp_i != 2'b00, if mem_rlast_i arrives with cnt < BEATS-1, or if beat BEATS-1 arrives without mem_rlast_i.
REQ-017 SHALL leave FILL for WRITE on the cycle after the beat with cnt = BEATS-1 or with mem_rlast_i, whichever is first.
REQ-018 WRITE, no error: SHALL assert wren_o for exactly one cycle with waddr_o=index, wdata_tag_o={1'b1,tag}, wdata_data_o=assembled line (slot 0 at LSBs), and pulse fill_done_o.
REQ-019 WRITE, error: SHALL keep wren_o=0, pulse fill_err_o, discard the line, clear the error flag.
REQ-020 WRITE with !miss_addr_fifo_empty_i: SHALL pop the next address in the same cycle and go directly to FILL (no bubble); otherwise go to IDLE.
REQ-021 Latency: miss pop to first possible beat acceptance = 1 cycle; last beat to wren_o = 1 cycle.
REQ-022 rvalid while not in FILL SHALL be ignored (not accepted, not stored).
REQ-023 wdata_* SHALL be don't-care when wren_o=0 but SHALL hold stable during WRITE.

Reset
REQ-024 On rst=1: state IDLE, cnt 0, error flag 0, line buffer 0; wren_o, miss_addr_fifo_rden_o, mem_rready_o, busy_o, fill_done_o, fill_err_o all 0.
REQ-025 rst asserted mid-FILL SHALL discard the partial line with no SRAM write and no error pulse.

Structure
REQ-026 Package cc_pkg SHALL hold the state enum, RESP_OKAY constant, and default parameter values shared with the decoder and tag comparator.
REQ-027 Beat-slot storage SHALL be a sub-module cc_line_buf (BEAT_W, BEATS; write-enable, slot index, beat data in; full line out).

Verification
REQ-028 Wrap fill: miss addr 0x0000_1238 (index 0x048 at defaults, start beat 7), 8 OKAY beats D0..D7, rlast on 8th -> wren_o one cycle, waddr 0x048, slot7=D0, slot0=D1 ... slot6=D7, fill_done_o=1.
REQ-029 WRAP_MODE=0 same stimulus -> slot k = Dk, tag valid bit 1.
REQ-030 SLVERR on beat 3 -> no wren_o, fill_err_o pulse, engine returns IDLE, next miss fills correctly.
REQ-031 Early rlast on beat 5 -> fill_err_o, no write; missing rlast on beat 8 -> fill_err_o, no write.
REQ-032 Two queued misses, rvalid held high -> second rden_o in WRITE cycle, second FILL starts next cycle, two wren_o 9 cycles apart.
REQ-033 rst pulsed after beat 4 -> all outputs 0 next cycle, no write; following miss fills with correct data.

Source files
------------

// File: rtl/cc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cc_pkg
// Brief   : Shared types and default parameters for the cache line fill path.
// Revision: 1.0 - initial release
// ============================================================================
package cc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Defaults shared with the address decoder and tag comparator
   localparam int BEAT_W_DEF    = 64;
   localparam int BEATS_DEF     = 8;
   localparam int IDX_W_DEF     = 9;
   localparam int TAG_W_DEF     = 17;
   localparam int WRAP_MODE_DEF = 1;

endpackage
`default_nettype wire

// File: rtl/cc_line_buf.sv
`default_nettype none
// ============================================================================
// Module  : cc_line_buf
// Brief   : Beat-slot storage for one cache line; slot 0 sits at the LSBs.
// Revision: 1.0 - initial release
// ============================================================================
module cc_line_buf
   import cc_pkg::*;
#(
   parameter int BEAT_W = BEAT_W_DEF,
   parameter int BEATS  = BEATS_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en_i,
   input  logic [$clog2(BEATS)-1:0]    slot_i,
   input  logic [BEAT_W-1:0]           beat_i,
   output logic [BEAT_W*BEATS-1:0]     line_o
);

   localparam int c_slot_w = $clog2(BEATS);

   for (genvar s = 0; s < BEATS; s++) begin : g_slot
      logic [BEAT_W-1:0] r_beat;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_beat <= '0;
         end else if (wr_en_i && (slot_i == c_slot_w'(s))) begin
            r_beat <= beat_i;
         end
      end

      assign line_o[s*BEAT_W +: BEAT_W] = r_beat;
   end

endmodule
`default_nettype wire

// File: rtl/cc_line_fill_engine.sv
`default_nettype none
// ============================================================================
// Module  : cc_line_fill_engine
// Brief   : Pops miss addresses, collects R-channel beats into a line, writes
//           the tag/data SRAM once per good fill and flags aborted fills.
// Revision: 1.0 - initial release
// ============================================================================
module cc_line_fill_engine
   import cc_pkg::*;
#(
   parameter int BEAT_W    = BEAT_W_DEF,
   parameter int BEATS     = BEATS_DEF,
   parameter int IDX_W     = IDX_W_DEF,
   parameter int TAG_W     = TAG_W_DEF,
   parameter int WRAP_MODE = WRAP_MODE_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       miss_addr_fifo_empty_i,
   input  logic [31:0]                miss_addr_fifo_rdata_i,
   output logic                       miss_addr_fifo_rden_o,
   input  logic [BEAT_W-1:0]          mem_rdata_i,
   input  logic [1:0]                 mem_rresp_i,
   input  logic                       mem_rlast_i,
   input  logic                       mem_rvalid_i,
   output logic                       mem_rready_o,
   output logic                       wren_o,
   output logic [IDX_W-1:0]           waddr_o,
   output logic [TAG_W:0]             wdata_tag_o,
   output logic [BEAT_W*BEATS-1:0]    wdata_data_o,
   output logic                       busy_o,
   output logic                       fill_done_o,
   output logic                       fill_err_o
);

   localparam int c_cnt_w  = $clog2(BEATS);
   localparam int c_byte_w = $clog2(BEAT_W/8);
   localparam int c_off_w  = c_cnt_w + c_byte_w;
   localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(BEATS-1);

   state_t                 r_state;
   state_t                 w_next;
   logic [c_cnt_w-1:0]     r_cnt;
   logic [c_cnt_w-1:0]     r_start;
   logic [c_cnt_w-1:0]     w_slot;
   logic [IDX_W-1:0]       r_idx;
   logic [TAG_W-1:0]       r_tag;
   logic                   r_err;
   logic                   w_pop;
   logic                   w_in_fill;
   logic                   w_in_write;
   logic                   w_accept;
   logic                   w_last_beat;
   logic                   w_beat_err;
   logic                   w_fill_end;
   logic                   w_unused;

   // Outputs are forced low while rst is held so nothing leaks out mid-reset
   assign w_in_fill   = (r_state == ST_FILL)  && !rst;
   assign w_in_write  = (r_state == ST_WRITE) && !rst;
   assign w_accept    = mem_rvalid_i && w_in_fill;
   assign w_last_beat = (r_cnt == c_last_cnt);
   assign w_beat_err  = (mem_rresp_i != RESP_OKAY) ||
                        (mem_rlast_i && !w_last_beat) ||
                        (w_last_beat && !mem_rlast_i);
   assign w_fill_end  = w_accept && (w_last_beat || mem_rlast_i);
   assign w_slot      = (WRAP_MODE != 0) ? (r_start + r_cnt) : r_cnt;
   assign w_unused    = ^miss_addr_fifo_rdata_i;

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               if (!miss_addr_fifo_empty_i) begin
                  w_pop  = 1'b1;
                  w_next = ST_FILL;
               end
            end
            ST_FILL: begin
               if (w_fill_end) w_next = ST_WRITE;
            end
            ST_WRITE: begin
               // Back-to-back misses chain straight into the next fill
               if (!miss_addr_fifo_empty_i) begin
                  w_pop  = 1'b1;
                  w_next = ST_FILL;
               end else begin
                  w_next = ST_IDLE;
               end
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_start <= '0;
         r_idx   <= '0;
         r_tag   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_pop) begin
            r_tag   <= miss_addr_fifo_rdata_i[c_off_w+IDX_W +: TAG_W];
            r_idx   <= miss_addr_fifo_rdata_i[c_off_w +: IDX_W];
            r_start <= miss_addr_fifo_rdata_i[c_byte_w +: c_cnt_w];
            r_cnt   <= '0;
         end else if (w_accept) begin
            r_cnt   <= r_cnt + 1'b1;
         end
         if (w_accept && w_beat_err) begin
            r_err <= 1'b1;
         end else if (r_state == ST_WRITE) begin
            r_err <= 1'b0;
         end
      end
   end

   cc_line_buf #(
      .BEAT_W (BEAT_W),
      .BEATS  (BEATS)
   ) u_line_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en_i (w_accept),
      .slot_i  (w_slot),
      .beat_i  (mem_rdata_i),
      .line_o  (wdata_data_o)
   );

   assign miss_addr_fifo_rden_o = w_pop;
   assign mem_rready_o          = w_in_fill;
   assign busy_o                = w_in_fill || w_in_write;
   assign wren_o                = w_in_write && !r_err;
   assign fill_done_o           = w_in_write && !r_err;
   assign fill_err_o            = w_in_write && r_err;
   assign waddr_o               = r_idx;
   assign wdata_tag_o           = {1'b1, r_tag};

endmodule
`default_nettype wire

// File: tb/tb_cc_line_fill_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_cc_line_fill_engine
// Brief   : Directed vector bench for the line fill engine, wrap and linear.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cc_line_fill_engine;

   logic         clk = 1'b0;
   logic         rst;
   logic         fifo_empty;
   logic [31:0]  fifo_rdata;
   logic [63:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;

   logic         rden, rready, wren, busy, done, ferr;
   logic [8:0]   waddr;
   logic [17:0]  wtag;
   logic [511:0] wdata;
   logic         rden0, rready0, wren0, busy0, done0, ferr0;
   logic [8:0]   waddr0;
   logic [17:0]  wtag0;
   logic [511:0] wdata0;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] addr;
      int          nb;
      int          last_i;
      int          err_i;
      bit          ok;
   } vec_t;

   vec_t tbl [6];

   always #5 clk = ~clk;

   cc_line_fill_engine dut (
      .clk(clk), .rst(rst),
      .miss_addr_fifo_empty_i(fifo_empty), .miss_addr_fifo_rdata_i(fifo_rdata),
      .miss_addr_fifo_rden_o(rden),
      .mem_rdata_i(rdata), .mem_rresp_i(rresp), .mem_rlast_i(rlast),
      .mem_rvalid_i(rvalid), .mem_rready_o(rready),
      .wren_o(wren), .waddr_o(waddr), .wdata_tag_o(wtag), .wdata_data_o(wdata),
      .busy_o(busy), .fill_done_o(done), .fill_err_o(ferr)
   );

   cc_line_fill_engine #(.WRAP_MODE(0)) dut0 (
      .clk(clk), .rst(rst),
      .miss_addr_fifo_empty_i(fifo_empty), .miss_addr_fifo_rdata_i(fifo_rdata),
      .miss_addr_fifo_rden_o(rden0),
      .mem_rdata_i(rdata), .mem_rresp_i(rresp), .mem_rlast_i(rlast),
      .mem_rvalid_i(rvalid), .mem_rready_o(rready0),
      .wren_o(wren0), .waddr_o(waddr0), .wdata_tag_o(wtag0), .wdata_data_o(wdata0),
      .busy_o(busy0), .fill_done_o(done0), .fill_err_o(ferr0)
   );

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] beat(input int v, input int k);
      return {16'hBEEF, v[15:0], 16'h0000, k[15:0]};
   endfunction

   task automatic run_fill(input int v, input vec_t t);
      int           start;
      logic [511:0] exp1;
      logic [511:0] exp0;
      start = int'(t.addr[5:3]);
      exp1  = '0;
      exp0  = '0;
      fifo_empty = 1'b0;
      fifo_rdata = t.addr;
      #1;
      chk("rden_pop", {rden, rden0}, 2'b11);
      @(posedge clk); #1;
      fifo_empty = 1'b1;
      fifo_rdata = '0;
      for (int k = 0; k < t.nb; k++) begin
         rvalid = 1'b1;
         rdata  = beat(v, k);
         rresp  = (k == t.err_i) ? 2'b10 : 2'b00;
         rlast  = (k == t.last_i);
         #1;
         if (k == 0) chk("rready_fill", {rready, rready0, busy}, 3'b111);
         exp1[((start + k) % 8)*64 +: 64] = rdata;
         exp0[k*64 +: 64]                 = rdata;
         @(posedge clk); #1;
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      #1;
      chk("write_flags", {wren, done, ferr, rready}, {t.ok, t.ok, !t.ok, 1'b0});
      chk("write_flags0", {wren0, done0, ferr0}, {t.ok, t.ok, !t.ok});
      if (t.ok) begin
         chk("waddr", waddr, t.addr[14:6]);
         chk("wtag", {wtag, wtag0}, {1'b1, t.addr[31:15], 1'b1, t.addr[31:15]});
         chk("wdata_wrap", wdata, exp1);
         chk("wdata_linear", wdata0, exp0);
      end
      @(posedge clk); #1;
      chk("back_idle", {busy, wren, done, ferr}, 4'b0000);
   endtask

   initial begin
      logic [511:0] exp_b;
      int w1, w2, bk;

      tbl[0] = '{32'h0000_1238, 8, 7, 99, 1'b1};   // start beat 7, index 0x048
      tbl[1] = '{32'h0000_2040, 8, 7, 3,  1'b0};   // SLVERR on beat 3
      tbl[2] = '{32'hABCD_8010, 8, 7, 99, 1'b1};   // recovers after error
      tbl[3] = '{32'h0000_1F00, 5, 4, 99, 1'b0};   // early rlast on 5th beat
      tbl[4] = '{32'h0001_0088, 8, 99, 99, 1'b0};  // rlast missing on 8th beat
      tbl[5] = '{32'hFFFF_FFC8, 8, 7, 99, 1'b1};   // start beat 1, max tag

      rst = 1'b1; fifo_empty = 1'b0; fifo_rdata = 32'h0000_1238;
      rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_outputs", {rden, rready, wren, busy, done, ferr}, 6'b0);
      rst = 1'b0; fifo_empty = 1'b1; rvalid = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_reset", {rden, rready, busy}, 3'b000);

      for (int i = 0; i < 6; i++) run_fill(i + 1, tbl[i]);

      // Two queued misses with rvalid held high
      w1 = -1; w2 = -1; exp_b = '0;
      for (int c = 0; c < 26; c++) begin
         fifo_empty = (c > 9);
         fifo_rdata = (c == 0) ? 32'h0000_3000 : 32'h0000_5068;
         rvalid     = 1'b1;
         rlast      = (c == 8) || (c == 17);
         rresp      = 2'b00;
         bk         = (c <= 8) ? c - 1 : c - 10;
         if (c >= 1 && c <= 8)       rdata = beat(40, bk);
         else if (c >= 10 && c <= 17) begin
            rdata = beat(41, bk);
            exp_b[((5 + bk) % 8)*64 +: 64] = rdata;
         end else                     rdata = 64'hDEAD_DEAD_DEAD_DEAD;
         #1;
         if (c == 0) chk("b2b_rden_idle", rden, 1'b1);
         if (c == 9) chk("b2b_rden_write", {rden, rready}, 2'b10);
         if (wren) begin
            if (w1 < 0) w1 = c;
            else if (w2 < 0) begin
               w2 = c;
               chk("b2b_waddr", waddr, 9'h141);
               chk("b2b_wdata", wdata, exp_b);
            end
         end
         @(posedge clk); #1;
      end
      rvalid = 1'b0; rlast = 1'b0;
      chk("b2b_first_wren", w1, 9);
      chk("b2b_second_wren", w2, 18);

      // Reset in the middle of a fill
      fifo_empty = 1'b0; fifo_rdata = 32'h0000_1238;
      @(posedge clk); #1;
      fifo_empty = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rvalid = 1'b1; rdata = beat(50, k); rlast = 1'b0;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("rst_mid_comb", {rready, busy, wren, ferr}, 4'b0000);
      @(posedge clk); #1;
      rst = 1'b0; rvalid = 1'b0;
      #1;
      chk("rst_mid_next", {rden, rready, busy, wren, done, ferr}, 6'b0);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (wren || ferr || done) chk("rst_mid_quiet", {wren, done, ferr}, 3'b000);
      end
      chk("rst_mid_idle", busy, 1'b0);
      run_fill(60, tbl[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
